// File: rtl/i2c_pkg.sv
// Shared I2C definitions: state encoding, ACK levels and bus widths.
// Used by the target and usable by the main controller.
package i2c_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned I2C_DATA_W = 2 * I2C_BYTE_W;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    typedef enum logic [7:0] {
        StIdle    = 8'b0000_0001,
        StAddr    = 8'b0000_0010,
        StAddrAck = 8'b0000_0100,
        StWrByte  = 8'b0000_1000,
        StWrAck   = 8'b0001_0000,
        StRdByte  = 8'b0010_0000,
        StRdAck   = 8'b0100_0000,
        StIgnore  = 8'b1000_0000
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers plus history flops for SCL/SDA; emits SCL edge and
// START/STOP strobes together with the synchronized SDA level.
module i2c_line_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_hist;
    logic       r_sda_hist;
    logic       w_scl;
    logic       w_sda;

    // Preset to 1 so that leaving reset on an idle bus produces no edges.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_hist <= r_scl_sync[1];
            r_sda_hist <= r_sda_sync[1];
        end
    end

    assign w_scl = r_scl_sync[1];
    assign w_sda = r_sda_sync[1];

    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_hist;
    assign o_scl_fall = ~w_scl & r_scl_hist;
    assign o_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign o_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target endpoint: 7-bit address match, 16-bit word writes and reads
// (high byte first), oversampled with the system clock; never drives SCL.
module i2c_target
    import i2c_pkg::*;
#(
    parameter int unsigned ADDR_W = I2C_ADDR_W,
    parameter int unsigned DATA_W = I2C_DATA_W
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCL,
    input  logic              SDA_IN,
    input  logic [ADDR_W-1:0] I2C_ADDR,
    input  logic [DATA_W-1:0] RD_DATA,
    output logic              SDA_OUT,
    output logic              SDA_OE,
    output logic [DATA_W-1:0] WR_DATA,
    output logic              WR_STB,
    output logic              BUSY
);

    localparam int unsigned BW = I2C_BYTE_W;

    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_start;
    logic w_stop;

    i2c_line_sync u_line_sync (
        .i_clk      (CLK),
        .i_rst_n    (RESET),
        .i_scl      (SCL),
        .i_sda      (SDA_IN),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_state_e        r_state,    w_state_nxt;
    logic [3:0]        r_bit_cnt,  w_bit_cnt_nxt;
    logic [BW-1:0]     r_shift,    w_shift_nxt;
    logic              r_rnw,      w_rnw_nxt;
    logic              r_byte_tgl, w_byte_tgl_nxt;
    logic              r_phase,    w_phase_nxt;
    logic [BW-1:0]     r_hi_byte,  w_hi_byte_nxt;
    logic [BW-1:0]     r_lo_byte,  w_lo_byte_nxt;
    logic [DATA_W-1:0] r_rd_word,  w_rd_word_nxt;
    logic [DATA_W-1:0] r_wr_data,  w_wr_data_nxt;
    logic              r_wr_stb,   w_wr_stb_nxt;
    logic              r_busy,     w_busy_nxt;
    logic              r_sda_out,  w_sda_out_nxt;
    logic              r_sda_oe,   w_sda_oe_nxt;
    logic [BW-1:0]     w_rx_byte;
    logic [BW-1:0]     w_tx_byte;
    logic              w_tx_load;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= StIdle;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_rnw      <= 1'b0;
            r_byte_tgl <= 1'b0;
            r_phase    <= 1'b0;
            r_hi_byte  <= '0;
            r_lo_byte  <= '0;
            r_rd_word  <= '0;
            r_wr_data  <= '0;
            r_wr_stb   <= 1'b0;
            r_busy     <= 1'b0;
            r_sda_out  <= 1'b1;
            r_sda_oe   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rnw      <= w_rnw_nxt;
            r_byte_tgl <= w_byte_tgl_nxt;
            r_phase    <= w_phase_nxt;
            r_hi_byte  <= w_hi_byte_nxt;
            r_lo_byte  <= w_lo_byte_nxt;
            r_rd_word  <= w_rd_word_nxt;
            r_wr_data  <= w_wr_data_nxt;
            r_wr_stb   <= w_wr_stb_nxt;
            r_busy     <= w_busy_nxt;
            r_sda_out  <= w_sda_out_nxt;
            r_sda_oe   <= w_sda_oe_nxt;
        end
    end

    assign w_rx_byte = {r_shift[BW-2:0], w_sda};

    always_comb begin
        w_state_nxt    = r_state;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_rnw_nxt      = r_rnw;
        w_byte_tgl_nxt = r_byte_tgl;
        w_phase_nxt    = r_phase;
        w_hi_byte_nxt  = r_hi_byte;
        w_lo_byte_nxt  = r_lo_byte;
        w_rd_word_nxt  = r_rd_word;
        w_wr_data_nxt  = r_wr_data;
        w_wr_stb_nxt   = 1'b0;
        w_busy_nxt     = r_busy;
        w_sda_out_nxt  = r_sda_out;
        w_sda_oe_nxt   = r_sda_oe;
        w_tx_byte      = '0;
        w_tx_load      = 1'b0;

        if (w_start || w_stop) begin
            w_state_nxt    = w_start ? StAddr : StIdle;
            w_bit_cnt_nxt  = '0;
            w_shift_nxt    = '0;
            w_byte_tgl_nxt = 1'b0;
            w_phase_nxt    = 1'b0;
            w_busy_nxt     = 1'b0;
            w_sda_out_nxt  = 1'b1;
            w_sda_oe_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StIgnore: ;
                StAddr: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = '0;
                            w_rnw_nxt     = w_sda;
                            w_phase_nxt   = 1'b0;
                            if (r_shift[ADDR_W-1:0] == I2C_ADDR) begin
                                w_state_nxt = StAddrAck;
                                w_busy_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = StIgnore;
                            end
                        end
                    end
                end
                // First fall starts the ACK low; second fall ends it.
                StAddrAck, StWrAck: begin
                    if (w_scl_fall) begin
                        if (!r_phase) begin
                            w_sda_oe_nxt  = 1'b1;
                            w_sda_out_nxt = ACK;
                            w_phase_nxt   = 1'b1;
                        end else if (r_state == StAddrAck && r_rnw) begin
                            w_rd_word_nxt  = RD_DATA;
                            w_tx_byte      = RD_DATA[DATA_W-1 -: BW];
                            w_byte_tgl_nxt = 1'b0;
                            w_tx_load      = 1'b1;
                        end else begin
                            w_phase_nxt   = 1'b0;
                            w_sda_oe_nxt  = 1'b0;
                            w_sda_out_nxt = 1'b1;
                            w_bit_cnt_nxt = '0;
                            w_state_nxt   = StWrByte;
                            if (r_state == StWrAck) begin
                                w_byte_tgl_nxt = ~r_byte_tgl;
                                if (r_byte_tgl) begin
                                    w_wr_data_nxt = {r_hi_byte, r_lo_byte};
                                    w_wr_stb_nxt  = 1'b1;
                                end
                            end
                        end
                    end
                end
                StWrByte: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_rx_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = '0;
                            w_phase_nxt   = 1'b0;
                            w_state_nxt   = StWrAck;
                            if (r_byte_tgl) w_lo_byte_nxt = w_rx_byte;
                            else            w_hi_byte_nxt = w_rx_byte;
                        end
                    end
                end
                StRdByte: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_oe_nxt  = 1'b0;
                            w_sda_out_nxt = 1'b1;
                            w_bit_cnt_nxt = '0;
                            w_phase_nxt   = 1'b0;
                            w_state_nxt   = StRdAck;
                        end else begin
                            w_sda_out_nxt = r_shift[BW-1];
                            w_shift_nxt   = {r_shift[BW-2:0], 1'b0};
                            w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        end
                    end
                end
                StRdAck: begin
                    if (w_scl_rise) begin
                        if (w_sda == NACK) w_state_nxt = StIgnore;
                        else               w_phase_nxt = 1'b1;
                    end else if (w_scl_fall && r_phase) begin
                        // Low byte comes from the captured word; a new word loads after it.
                        if (!r_byte_tgl) begin
                            w_tx_byte      = r_rd_word[BW-1:0];
                            w_byte_tgl_nxt = 1'b1;
                        end else begin
                            w_rd_word_nxt  = RD_DATA;
                            w_tx_byte      = RD_DATA[DATA_W-1 -: BW];
                            w_byte_tgl_nxt = 1'b0;
                        end
                        w_tx_load = 1'b1;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase

            if (w_tx_load) begin
                w_sda_oe_nxt  = 1'b1;
                w_sda_out_nxt = w_tx_byte[BW-1];
                w_shift_nxt   = {w_tx_byte[BW-2:0], 1'b0};
                w_bit_cnt_nxt = 4'd1;
                w_phase_nxt   = 1'b0;
                w_state_nxt   = StRdByte;
            end
        end
    end

    assign SDA_OUT = r_sda_out;
    assign SDA_OE  = r_sda_oe;
    assign WR_DATA = r_wr_data;
    assign WR_STB  = r_wr_stb;
    assign BUSY    = r_busy;

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_i2c_target;

    localparam int Q = 5;  // quarter SCL period in CLK cycles

    logic        clk;
    logic        rst_n;
    logic        scl;
    logic        sda_c;
    logic [6:0]  own_addr;
    logic [15:0] rd_data;
    logic        sda_out;
    logic        sda_oe;
    logic [15:0] wr_data;
    logic        wr_stb;
    logic        busy;
    logic        sda_bus;

    int n_checks = 0;
    int n_pass   = 0;
    int stb_cnt  = 0;
    int oe_hits  = 0;
    int oe_rises = 0;
    logic oe_prev = 1'b0;

    logic [15:0] m_wr;  // model: expected WR_DATA

    assign sda_bus = sda_c & ~(sda_oe & ~sda_out);

    i2c_target #(
        .ADDR_W (7),
        .DATA_W (16)
    ) dut (
        .CLK      (clk),
        .RESET    (rst_n),
        .SCL      (scl),
        .SDA_IN   (sda_bus),
        .I2C_ADDR (own_addr),
        .RD_DATA  (rd_data),
        .SDA_OUT  (sda_out),
        .SDA_OE   (sda_oe),
        .WR_DATA  (wr_data),
        .WR_STB   (wr_stb),
        .BUSY     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        oe_prev <= sda_oe;
        if (wr_stb) stb_cnt <= stb_cnt + 1;
        if (sda_oe) oe_hits <= oe_hits + 1;
        if (sda_oe && !oe_prev) oe_rises <= oe_rises + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bit_xfer(input logic b, output logic seen);
        repeat (Q) @(negedge clk);
        sda_c = b;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        seen = sda_bus;
        repeat (Q) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic i2c_start();
        repeat (Q) @(negedge clk);
        sda_c = 1'b1;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (2 * Q) @(negedge clk);
        sda_c = 1'b0;
        repeat (2 * Q) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        repeat (Q) @(negedge clk);
        sda_c = 1'b0;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (2 * Q) @(negedge clk);
        sda_c = 1'b1;
        repeat (2 * Q) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
        bit_xfer(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, s);
            b[i] = s;
        end
        bit_xfer(mack, s);
    endtask

    logic        ack;
    logic        s;
    logic [7:0]  rb;
    logic [7:0]  bytes [8];
    logic [15:0] words [4];
    int          stb0;
    int          oe0;
    int          n;
    logic        match;
    logic        rnw;
    logic [6:0]  addr;

    initial begin
        rst_n    = 1'b0;
        scl      = 1'b1;
        sda_c    = 1'b1;
        own_addr = 7'h42;
        rd_data  = 16'h0;
        m_wr     = 16'h0;
        repeat (4) @(negedge clk);
        check_eq("rst_sda_oe", {31'b0, sda_oe}, 32'd0);
        check_eq("rst_sda_out", {31'b0, sda_out}, 32'd1);
        check_eq("rst_wr_data", {16'b0, wr_data}, 32'd0);
        check_eq("rst_wr_stb", {31'b0, wr_stb}, 32'd0);
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Write 0xBEEF to 0x42.
        stb0 = stb_cnt;
        oe0  = oe_rises;
        i2c_start();
        send_byte({7'h42, 1'b0}, ack);
        check_eq("wr_addr_ack", {31'b0, ack}, 32'd0);
        check_eq("wr_busy", {31'b0, busy}, 32'd1);
        send_byte(8'hBE, ack);
        check_eq("wr_b0_ack", {31'b0, ack}, 32'd0);
        send_byte(8'hEF, ack);
        check_eq("wr_b1_ack", {31'b0, ack}, 32'd0);
        i2c_stop();
        m_wr = 16'hBEEF;
        check_eq("wr_data", {16'b0, wr_data}, {16'b0, m_wr});
        check_eq("wr_stb_cnt", stb_cnt - stb0, 32'd1);
        check_eq("wr_ack_pulses", oe_rises - oe0, 32'd3);
        check_eq("wr_busy_stop", {31'b0, busy}, 32'd0);

        // Read 0x1234: ACK high byte, NACK low byte.
        rd_data = 16'h1234;
        i2c_start();
        send_byte({7'h42, 1'b1}, ack);
        check_eq("rd_addr_ack", {31'b0, ack}, 32'd0);
        recv_byte(1'b0, rb);
        check_eq("rd_hi", {24'b0, rb}, 32'h12);
        recv_byte(1'b1, rb);
        check_eq("rd_lo", {24'b0, rb}, 32'h34);
        repeat (Q) @(negedge clk);
        check_eq("rd_oe_after_nack", {31'b0, sda_oe}, 32'd0);
        i2c_stop();

        // Address mismatch.
        stb0 = stb_cnt;
        oe0  = oe_hits;
        i2c_start();
        send_byte({7'h43, 1'b0}, ack);
        check_eq("mm_addr_nack", {31'b0, ack}, 32'd1);
        check_eq("mm_busy", {31'b0, busy}, 32'd0);
        send_byte(8'h55, ack);
        send_byte(8'h66, ack);
        i2c_stop();
        check_eq("mm_oe_hits", oe_hits - oe0, 32'd0);
        check_eq("mm_stb", stb_cnt - stb0, 32'd0);
        check_eq("mm_wr_data", {16'b0, wr_data}, {16'b0, m_wr});

        // Partial write then repeated START into a read.
        stb0 = stb_cnt;
        rd_data = 16'hC3A5;
        i2c_start();
        send_byte({7'h42, 1'b0}, ack);
        send_byte(8'hAA, ack);
        check_eq("rs_wr_ack", {31'b0, ack}, 32'd0);
        i2c_start();
        send_byte({7'h42, 1'b1}, ack);
        check_eq("rs_rd_ack", {31'b0, ack}, 32'd0);
        recv_byte(1'b1, rb);
        check_eq("rs_rd_hi", {24'b0, rb}, 32'hC3);
        i2c_stop();
        check_eq("rs_stb", stb_cnt - stb0, 32'd0);
        check_eq("rs_wr_data", {16'b0, wr_data}, {16'b0, m_wr});

        // Reset while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_xfer(((8'h84 >> i) & 8'h1) != 0, s);
        repeat (Q) @(negedge clk);
        sda_c = 1'b1;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        check_eq("rst_pre_oe", {31'b0, sda_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_eq("rst_async_oe", {31'b0, sda_oe}, 32'd0);
        m_wr = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (Q) @(negedge clk);
        scl = 1'b0;
        i2c_stop();
        stb0 = stb_cnt;
        i2c_start();
        send_byte({7'h42, 1'b0}, ack);
        send_byte(8'h5A, ack);
        send_byte(8'h5A, ack);
        check_eq("rst_wr_ack", {31'b0, ack}, 32'd0);
        i2c_stop();
        m_wr = 16'h5A5A;
        check_eq("rst_wr_data", {16'b0, wr_data}, {16'b0, m_wr});
        check_eq("rst_wr_stb", stb_cnt - stb0, 32'd1);

        // STOP four bits into the low byte.
        stb0 = stb_cnt;
        i2c_start();
        send_byte({7'h42, 1'b0}, ack);
        send_byte(8'h11, ack);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, s);
        i2c_stop();
        check_eq("ps_wr_data", {16'b0, wr_data}, {16'b0, m_wr});
        check_eq("ps_stb", stb_cnt - stb0, 32'd0);
        check_eq("ps_busy", {31'b0, busy}, 32'd0);

        // Randomized transactions against the model.
        for (int t = 0; t < 24; t++) begin
            addr     = 7'($urandom_range(0, 127));
            match    = ($urandom_range(0, 3) != 0);
            own_addr = match ? addr : (addr ^ (7'b1 << $urandom_range(0, 6)));
            rnw      = 1'($urandom_range(0, 1));
            n        = $urandom_range(1, 5);
            stb0     = stb_cnt;
            for (int i = 0; i < 8; i++) bytes[i] = 8'($urandom);
            for (int i = 0; i < 4; i++) words[i] = 16'($urandom);
            rd_data = words[0];
            i2c_start();
            send_byte({addr, rnw}, ack);
            check_eq("rnd_addr_ack", {31'b0, ack}, match ? 32'd0 : 32'd1);
            check_eq("rnd_busy", {31'b0, busy}, {31'b0, match});
            for (int i = 0; i < n; i++) begin
                if (!rnw) begin
                    send_byte(bytes[i], ack);
                    check_eq("rnd_wr_ack", {31'b0, ack}, match ? 32'd0 : 32'd1);
                end else begin
                    recv_byte(i == n - 1, rb);
                    if (i % 2 == 0) rd_data = words[i / 2 + 1];
                    check_eq("rnd_rd_byte", {24'b0, rb}, !match ? 32'hFF :
                             (i % 2 == 0) ? {24'b0, words[i / 2][15:8]} :
                             {24'b0, words[i / 2][7:0]});
                end
            end
            i2c_stop();
            if (match && !rnw && n >= 2)
                m_wr = {bytes[(n / 2 - 1) * 2], bytes[(n / 2 - 1) * 2 + 1]};
            check_eq("rnd_stb", stb_cnt - stb0, (match && !rnw) ? 32'(n / 2) : 32'd0);
            check_eq("rnd_wr_data", {16'b0, wr_data}, {16'b0, m_wr});
            check_eq("rnd_busy_stop", {31'b0, busy}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
